regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
- Parametrised successor to the CPU's 32x32 general-purpose register file.
- Generalised in data width, depth and read-port count.
- Adds synchronous reset, registered reads, byte-lane write strobes, read-during-write forwarding and an optional hardwired zero register.
- Sits in the decode stage: read ports feed the ALU operand muxes, and the write port is driven from write-back.

Parameters:
- DATA_WIDTH, 32, bits per register; must be a multiple of 8.
- ADDR_WIDTH, 5, register address width; DEPTH = 2**ADDR_WIDTH entries.
- NUM_READ, 2, number of independent read ports (1..4).
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is an ordinary register.
- BYPASS, 1, 1 = same-cycle write data is forwarded to a matching read; 0 = a matching read returns the pre-write contents.

Ports:
- clock_in, input, 1, sole clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high; clears all entries and outputs.
- read_en, input, NUM_READ, per-port read enable; bit i belongs to port i.
- read_addr, input, NUM_READ*ADDR_WIDTH, flattened addresses; port i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- read_data, output, NUM_READ*DATA_WIDTH, flattened registered read data; port i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- write_en, input, 1, write request.
- write_addr, input, ADDR_WIDTH, write address.
- write_be, input, DATA_WIDTH/8, byte-lane enables; bit k covers data bits [8k+7:8k].
- write_data, input, DATA_WIDTH, write data.

Behaviour:
- Clock and edge: single clock domain; all state changes on posedge clock_in. The old negedge write scheme is retired.
- Reset:
  - When reset=1 at a posedge, every storage entry becomes 0 and every read_data lane becomes 0.
  - Reset has priority over any write or read presented in the same cycle; those are discarded.
  - A reset asserted mid-stream takes effect at that edge. No partial write survives.
- Write:
  - When write_en=1 and reset=0 at a posedge, entry[write_addr] is updated lane by lane.
  - Lanes with write_be[k]=1 take write_data; lanes with write_be[k]=0 keep their old value.
  - write_be all-zero is a legal no-op.
- Zero register:
  - With ZERO_REG=1, a write to address 0 is dropped.
  - Reads of address 0 return 0 regardless of BYPASS or pending writes.
- Read timing:
  - Latency is 1 cycle.
  - When read_en[i]=1 at posedge N, read_data lane i holds the result from edge N until the next enabled read on that port or reset.
  - When read_en[i]=0, lane i holds its previous value.
- Read-during-write, same address, same edge:
  - BYPASS=1: the returned value is the merged post-write word (enabled lanes from write_data, other lanes from the old entry).
  - BYPASS=0: the returned value is the old entry.
- Multiple read ports:
  - All ports are independent and may address the same entry in the same cycle; each sees the identical value.
- Address range: no out-of-range case exists, since DEPTH = 2**ADDR_WIDTH.
- Storage and timing:
  - Storage is a reg array. No combinational path exists from any input to read_data.
  - Initial contents before the first reset are unspecified; the bench must reset first.

Test Plan:
1. Reset, then read: reset high for 1 cycle, then read_en=2'b11 with addresses 5 and 31 -> both lanes read 32'h0 one cycle later. Apply reset in the same cycle as a write of 32'hDEADBEEF to address 7 -> a later read of 7 returns 0.
2. Basic write/read with hold: write 32'h12345678 to address 3 with write_be=4'hF. Next cycle read port 0 at address 3 -> 32'h12345678. Drop read_en[0] and write 32'hAAAAAAAA to address 3 -> lane 0 still shows 32'h12345678.
3. Byte enables: address 9 holds 32'h11223344; write 32'hAABBCCDD with write_be=4'b0101 -> a subsequent read returns 32'h11BB33DD.
4. Forwarding: address 4 holds 32'h0; same edge, write 32'hCAFEF00D to address 4 (write_be=4'hF) and read address 4 on both ports. BYPASS=1 -> both lanes show 32'hCAFEF00D. BYPASS=0 build -> both lanes show 32'h0, and the next read shows 32'hCAFEF00D.
5. Zero register: write 32'hFFFFFFFF to address 0 with forwarding active. ZERO_REG=1 -> reads of 0 return 0 that cycle and afterwards. ZERO_REG=0 build -> the next read returns 32'hFFFFFFFF.
6. Parameter sweep: DATA_WIDTH=16, ADDR_WIDTH=3, NUM_READ=3. Write a unique 16-bit value to each of the 8 entries, then read all entries across 3 ports with rotating addresses -> every lane matches its value with exactly 1-cycle latency.

Source files
------------

// File: rtl/regfile_param.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_param
//  Purpose  : Parametrised multi-read, single-write register file with
//             synchronous reset, registered reads, byte-lane write strobes,
//             optional read-during-write forwarding and optional hardwired
//             zero register. Feeds the ALU operand muxes from decode and
//             takes its write port from write-back.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                           clock_in,
    input  logic                           reset,
    input  logic [NUM_READ-1:0]            read_en,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] read_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
    input  logic                           write_en,
    input  logic [ADDR_WIDTH-1:0]          write_addr,
    input  logic [DATA_WIDTH/8-1:0]        write_be,
    input  logic [DATA_WIDTH-1:0]          write_data
);

    localparam int c_DEPTH     = 2 ** ADDR_WIDTH;
    localparam int c_NUM_LANES = DATA_WIDTH / 8;
    localparam bit c_ZERO_ON   = (ZERO_REG != 0);
    localparam bit c_BYPASS_ON = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [DATA_WIDTH-1:0] w_writeMerged;
    logic                  w_writeTakes;

    // A write to entry 0 is discarded when entry 0 is hardwired to zero.
    assign w_writeTakes = write_en && !(c_ZERO_ON && (write_addr == '0));

    // Post-write word: strobed lanes from write_data, the rest from the entry.
    always_comb begin
        w_writeMerged = r_mem[write_addr];
        for (int k = 0; k < c_NUM_LANES; k++) begin
            if (write_be[k]) begin
                w_writeMerged[8*k +: 8] = write_data[8*k +: 8];
            end
        end
    end

    // Storage update; reset wins over any write presented on the same edge.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_writeTakes) begin
            r_mem[write_addr] <= w_writeMerged;
        end
    end

    generate
        for (genvar p = 0; p < NUM_READ; p++) begin : g_readPort
            logic [ADDR_WIDTH-1:0] w_addr;
            logic [DATA_WIDTH-1:0] w_value;
            logic [DATA_WIDTH-1:0] r_data;

            assign w_addr = read_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

            // Read source: zero register beats forwarding, forwarding beats storage.
            always_comb begin
                w_value = r_mem[w_addr];
                if (c_BYPASS_ON && w_writeTakes && (w_addr == write_addr)) begin
                    w_value = w_writeMerged;
                end
                if (c_ZERO_ON && (w_addr == '0)) begin
                    w_value = '0;
                end
            end

            // Registered read lane; holds its value while the port is idle.
            always_ff @(posedge clock_in) begin
                if (reset) begin
                    r_data <= '0;
                end else if (read_en[p]) begin
                    r_data <= w_value;
                end
            end

            assign read_data[p*DATA_WIDTH +: DATA_WIDTH] = r_data;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_param
//  Purpose  : Directed self-checking bench for regfile_param. Three builds:
//             default (forwarding + zero register), no-forwarding/no-zero,
//             and a 16-bit / 8-entry / 3-port variant.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  rdEn;
    logic [9:0]  rdAddr;
    logic        wrEn;
    logic [4:0]  wrAddr;
    logic [3:0]  wrBe;
    logic [31:0] wrData;
    logic [63:0] rdDataA;
    logic [63:0] rdDataB;

    logic [2:0]  rdEnC;
    logic [8:0]  rdAddrC;
    logic        wrEnC;
    logic [2:0]  wrAddrC;
    logic [1:0]  wrBeC;
    logic [15:0] wrDataC;
    logic [47:0] rdDataC;

    int checks   = 0;
    int failures = 0;

    regfile_param #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(1), .BYPASS(1)
    ) dutA (
        .clock_in(clk), .reset(rst), .read_en(rdEn), .read_addr(rdAddr),
        .read_data(rdDataA), .write_en(wrEn), .write_addr(wrAddr),
        .write_be(wrBe), .write_data(wrData)
    );

    regfile_param #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(0), .BYPASS(0)
    ) dutB (
        .clock_in(clk), .reset(rst), .read_en(rdEn), .read_addr(rdAddr),
        .read_data(rdDataB), .write_en(wrEn), .write_addr(wrAddr),
        .write_be(wrBe), .write_data(wrData)
    );

    regfile_param #(
        .DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_READ(3), .ZERO_REG(0), .BYPASS(1)
    ) dutC (
        .clock_in(clk), .reset(rst), .read_en(rdEnC), .read_addr(rdAddrC),
        .read_data(rdDataC), .write_en(wrEnC), .write_addr(wrAddrC),
        .write_be(wrBeC), .write_data(wrDataC)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        wrEn = 1'b1; wrAddr = a; wrData = d; wrBe = be;
        tick();
        wrEn = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({rdDataA, rdDataB, rdDataC} !== 176'h0) begin
            failures++;
            $display("FAIL reset_outputs got A=%h B=%h C=%h exp all zero", rdDataA, rdDataB, rdDataC);
        end
        wr(5'd5, 32'h0000_0055, 4'hF);
        wr(5'd31, 32'h0000_0031, 4'hF);
        // reset together with a write to 7
        rst = 1'b1; wrEn = 1'b1; wrAddr = 5'd7; wrData = 32'hDEAD_BEEF; wrBe = 4'hF;
        tick();
        rst = 1'b0; wrEn = 1'b0;
        rdEn = 2'b11; rdAddr = {5'd31, 5'd5};
        tick();
        checks++;
        if (rdDataA !== 64'h0) begin
            failures++;
            $display("FAIL reset_read_5_31_A got=%h exp=%h", rdDataA, 64'h0);
        end
        checks++;
        if (rdDataB !== 64'h0) begin
            failures++;
            $display("FAIL reset_read_5_31_B got=%h exp=%h", rdDataB, 64'h0);
        end
        rdEn = 2'b01; rdAddr = {5'd0, 5'd7};
        tick();
        rdEn = 2'b00;
        checks++;
        if (rdDataA[31:0] !== 32'h0 || rdDataB[31:0] !== 32'h0) begin
            failures++;
            $display("FAIL reset_drops_write7 got A=%h B=%h exp=0", rdDataA[31:0], rdDataB[31:0]);
        end
    endtask

    task automatic test_basic_hold;
        wr(5'd3, 32'h1234_5678, 4'hF);
        rdEn = 2'b01; rdAddr = {5'd0, 5'd3};
        tick();
        checks++;
        if (rdDataA[31:0] !== 32'h1234_5678 || rdDataB[31:0] !== 32'h1234_5678) begin
            failures++;
            $display("FAIL basic_read got A=%h B=%h exp=12345678", rdDataA[31:0], rdDataB[31:0]);
        end
        rdEn = 2'b00;
        wr(5'd3, 32'hAAAA_AAAA, 4'hF);
        checks++;
        if (rdDataA[31:0] !== 32'h1234_5678 || rdDataB[31:0] !== 32'h1234_5678) begin
            failures++;
            $display("FAIL hold_when_disabled got A=%h B=%h exp=12345678", rdDataA[31:0], rdDataB[31:0]);
        end
        rdEn = 2'b01;
        tick();
        rdEn = 2'b00;
        checks++;
        if (rdDataA[31:0] !== 32'hAAAA_AAAA || rdDataB[31:0] !== 32'hAAAA_AAAA) begin
            failures++;
            $display("FAIL reread_after_write got A=%h B=%h exp=aaaaaaaa", rdDataA[31:0], rdDataB[31:0]);
        end
    endtask

    task automatic test_byte_enable;
        wr(5'd9, 32'h1122_3344, 4'hF);
        wr(5'd9, 32'hAABB_CCDD, 4'b0101);
        rdEn = 2'b10; rdAddr = {5'd9, 5'd0};
        tick();
        rdEn = 2'b00;
        checks++;
        if (rdDataA[63:32] !== 32'h11BB_33DD || rdDataB[63:32] !== 32'h11BB_33DD) begin
            failures++;
            $display("FAIL byte_enable_0101 got A=%h B=%h exp=11bb33dd", rdDataA[63:32], rdDataB[63:32]);
        end
        wr(5'd9, 32'hFFFF_FFFF, 4'b0000);
        rdEn = 2'b10;
        tick();
        rdEn = 2'b00;
        checks++;
        if (rdDataA[63:32] !== 32'h11BB_33DD || rdDataB[63:32] !== 32'h11BB_33DD) begin
            failures++;
            $display("FAIL byte_enable_none got A=%h B=%h exp=11bb33dd", rdDataA[63:32], rdDataB[63:32]);
        end
    endtask

    task automatic test_forwarding;
        wr(5'd4, 32'h0, 4'hF);
        wrEn = 1'b1; wrAddr = 5'd4; wrData = 32'hCAFE_F00D; wrBe = 4'hF;
        rdEn = 2'b11; rdAddr = {5'd4, 5'd4};
        tick();
        wrEn = 1'b0;
        checks++;
        if (rdDataA !== {2{32'hCAFE_F00D}}) begin
            failures++;
            $display("FAIL forward_bypass_on got=%h exp=%h", rdDataA, {2{32'hCAFE_F00D}});
        end
        checks++;
        if (rdDataB !== 64'h0) begin
            failures++;
            $display("FAIL forward_bypass_off got=%h exp=%h", rdDataB, 64'h0);
        end
        tick();
        checks++;
        if (rdDataB !== {2{32'hCAFE_F00D}} || rdDataA !== {2{32'hCAFE_F00D}}) begin
            failures++;
            $display("FAIL forward_next_read got A=%h B=%h exp=%h", rdDataA, rdDataB, {2{32'hCAFE_F00D}});
        end
        // partial-lane write while reading the same entry
        wrEn = 1'b1; wrData = 32'h1111_1111; wrBe = 4'b0011;
        tick();
        wrEn = 1'b0; rdEn = 2'b00;
        checks++;
        if (rdDataA !== {2{32'hCAFE_1111}} || rdDataB !== {2{32'hCAFE_F00D}}) begin
            failures++;
            $display("FAIL forward_partial got A=%h B=%h exp A=%h B=%h", rdDataA, rdDataB,
                     {2{32'hCAFE_1111}}, {2{32'hCAFE_F00D}});
        end
    endtask

    task automatic test_zero_reg;
        wrEn = 1'b1; wrAddr = 5'd0; wrData = 32'hFFFF_FFFF; wrBe = 4'hF;
        rdEn = 2'b11; rdAddr = {5'd0, 5'd0};
        tick();
        wrEn = 1'b0;
        checks++;
        if (rdDataA !== 64'h0 || rdDataB !== 64'h0) begin
            failures++;
            $display("FAIL zero_same_cycle got A=%h B=%h exp both 0", rdDataA, rdDataB);
        end
        tick();
        rdEn = 2'b00;
        checks++;
        if (rdDataA !== 64'h0) begin
            failures++;
            $display("FAIL zero_reg_on_after got=%h exp=%h", rdDataA, 64'h0);
        end
        checks++;
        if (rdDataB !== {2{32'hFFFF_FFFF}}) begin
            failures++;
            $display("FAIL zero_reg_off_after got=%h exp=%h", rdDataB, {2{32'hFFFF_FFFF}});
        end
    endtask

    task automatic test_back_to_back;
        wrEn = 1'b1; wrBe = 4'hF;
        wrAddr = 5'd10; wrData = 32'h0000_0001; rdEn = 2'b00;
        tick();
        wrAddr = 5'd11; wrData = 32'h0000_0002; rdEn = 2'b01; rdAddr = {5'd0, 5'd10};
        tick();
        checks++;
        if (rdDataA[31:0] !== 32'h1 || rdDataB[31:0] !== 32'h1) begin
            failures++;
            $display("FAIL b2b_edge2 got A=%h B=%h exp=1", rdDataA[31:0], rdDataB[31:0]);
        end
        wrAddr = 5'd10; wrData = 32'h0000_0003; rdEn = 2'b11; rdAddr = {5'd11, 5'd10};
        tick();
        checks++;
        if (rdDataA !== {32'h2, 32'h3} || rdDataB !== {32'h2, 32'h1}) begin
            failures++;
            $display("FAIL b2b_edge3 got A=%h B=%h exp A=%h B=%h", rdDataA, rdDataB,
                     {32'h2, 32'h3}, {32'h2, 32'h1});
        end
        // reset mid-stream with a write and reads pending
        rst = 1'b1; wrAddr = 5'd12; wrData = 32'h0000_0005; rdAddr = {5'd12, 5'd10};
        tick();
        rst = 1'b0; wrEn = 1'b0;
        checks++;
        if (rdDataA !== 64'h0 || rdDataB !== 64'h0) begin
            failures++;
            $display("FAIL midstream_reset_out got A=%h B=%h exp both 0", rdDataA, rdDataB);
        end
        tick();
        rdEn = 2'b00;
        checks++;
        if (rdDataA !== 64'h0 || rdDataB !== 64'h0) begin
            failures++;
            $display("FAIL midstream_reset_mem got A=%h B=%h exp both 0", rdDataA, rdDataB);
        end
    endtask

    task automatic test_param_sweep;
        logic [15:0] vals [8];
        logic [15:0] prevExp [3];
        vals = '{16'h1F2E, 16'h3D4C, 16'h5B6A, 16'h7988,
                 16'h97A6, 16'hB5C4, 16'hD3E2, 16'hF100};
        for (int i = 0; i < 8; i++) begin
            wrEnC = 1'b1; wrAddrC = 3'(i); wrDataC = vals[i]; wrBeC = 2'b11;
            tick();
        end
        wrEnC = 1'b0;
        for (int p = 0; p < 3; p++) prevExp[p] = 16'h0;
        for (int c = 0; c < 8; c++) begin
            rdEnC = 3'b111;
            for (int p = 0; p < 3; p++) rdAddrC[p*3 +: 3] = 3'((c + p) % 8);
            #1;
            for (int p = 0; p < 3; p++) begin
                checks++;
                if (rdDataC[p*16 +: 16] !== prevExp[p]) begin
                    failures++;
                    $display("FAIL sweep_pre_edge c=%0d port=%0d got=%h exp=%h", c, p,
                             rdDataC[p*16 +: 16], prevExp[p]);
                end
            end
            tick();
            for (int p = 0; p < 3; p++) begin
                prevExp[p] = vals[(c + p) % 8];
                checks++;
                if (rdDataC[p*16 +: 16] !== prevExp[p]) begin
                    failures++;
                    $display("FAIL sweep_read c=%0d port=%0d got=%h exp=%h", c, p,
                             rdDataC[p*16 +: 16], prevExp[p]);
                end
            end
        end
        rdEnC = 3'b000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rdEn = '0; rdAddr = '0; wrEn = 1'b0; wrAddr = '0; wrBe = '0; wrData = '0;
        rdEnC = '0; rdAddrC = '0; wrEnC = 1'b0; wrAddrC = '0; wrBeC = '0; wrDataC = '0;
        test_reset();
        test_basic_hold();
        test_byte_enable();
        test_forwarding();
        test_zero_reg();
        test_back_to_back();
        test_param_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
